// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with tree-PLRU replacement.
// Valid/PLRU state is cleared by a one-set-per-cycle walk after reset or flush.
module btb_assoc #(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 6,
    parameter int WAYS      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] rd_pc,
    output logic             rd_hit,
    output logic             rd_taken,
    output logic [31:0]      rd_target,
    input  logic             upd_en,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             upd_taken,
    input  logic             flush,
    output logic             busy
);
    localparam int N_SETS    = 2 ** IDX_WIDTH;
    localparam int TAG_WIDTH = WIDTH - IDX_WIDTH - 2;
    localparam int PLRU_W    = (WAYS > 1) ? WAYS - 1 : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]           state;
    logic [IDX_WIDTH-1:0] ptr;

    logic [WAYS-1:0]      valid_q [N_SETS];
    logic [PLRU_W-1:0]    plru_q  [N_SETS];
    logic [TAG_WIDTH-1:0] tag_q   [N_SETS][WAYS];
    logic [31:0]          tgt_q   [N_SETS][WAYS];
    logic [1:0]           cnt_q   [N_SETS][WAYS];

    logic [IDX_WIDTH-1:0] rd_idx, up_idx;
    logic [TAG_WIDTH-1:0] rd_tag, up_tag;
    logic                 unused_pc_lsbs;

    assign rd_idx = rd_pc[IDX_WIDTH+1:2];
    assign up_idx = upd_pc[IDX_WIDTH+1:2];
    assign rd_tag = rd_pc[WIDTH-1:IDX_WIDTH+2];
    assign up_tag = upd_pc[WIDTH-1:IDX_WIDTH+2];
    assign unused_pc_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};

    assign busy = (state == CLEAR);

    logic        lk_hit;
    logic [31:0] lk_tgt;
    logic [1:0]  lk_cnt;

    always_comb begin
        lk_hit = 1'b0;
        lk_tgt = '0;
        lk_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
                lk_hit = 1'b1;
                lk_tgt = tgt_q[rd_idx][w];
                lk_cnt = cnt_q[rd_idx][w];
            end
        end
    end

    logic       up_hit, up_free, up_we;
    logic [1:0] hit_way, free_way, vic_way, up_way;
    logic [1:0] up_cnt_old, up_cnt;
    logic [2:0] plru_cur, plru_nxt;

    always_comb begin
        up_hit     = 1'b0;
        up_free    = 1'b0;
        hit_way    = '0;
        free_way   = '0;
        up_cnt_old = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!up_hit && valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
                up_hit     = 1'b1;
                hit_way    = 2'(w);
                up_cnt_old = cnt_q[up_idx][w];
            end
            if (!up_free && !valid_q[up_idx][w]) begin
                up_free  = 1'b1;
                free_way = 2'(w);
            end
        end
    end

    // Tree bits point at the less-recently-used half; bit 0 is the root.
    always_comb begin
        plru_cur = 3'(plru_q[up_idx]);
        vic_way  = 2'd0;
        if (WAYS == 4)
            vic_way = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
        else if (WAYS == 2)
            vic_way = {1'b0, plru_cur[0]};
        up_way = up_hit ? hit_way : (up_free ? free_way : vic_way);
        plru_nxt = 3'd0;
        if (WAYS == 4) begin
            plru_nxt    = plru_cur;
            plru_nxt[0] = ~up_way[1];
            if (up_way[1])
                plru_nxt[2] = ~up_way[0];
            else
                plru_nxt[1] = ~up_way[0];
        end else if (WAYS == 2) begin
            plru_nxt = {2'b00, ~up_way[0]};
        end
        if (!up_hit)
            up_cnt = 2'b10;
        else if (upd_taken)
            up_cnt = (up_cnt_old == 2'd3) ? 2'd3 : up_cnt_old + 2'd1;
        else
            up_cnt = (up_cnt_old == 2'd0) ? 2'd0 : up_cnt_old - 2'd1;
    end

    assign up_we = (state == IDLE) && upd_en && !flush && (up_hit || upd_taken);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            ptr       <= '0;
            rd_hit    <= 1'b0;
            rd_taken  <= 1'b0;
            rd_target <= '0;
        end else begin
            if (rd_en) begin
                rd_hit    <= lk_hit && !busy;
                rd_taken  <= lk_hit && !busy && lk_cnt[1];
                rd_target <= (lk_hit && !busy) ? lk_tgt : 32'd0;
            end
            if (state == CLEAR) begin
                ptr <= ptr + 1'b1;
                if (ptr == IDX_WIDTH'(N_SETS - 1))
                    state <= IDLE;
            end else if (flush) begin
                state <= CLEAR;
                ptr   <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                valid_q[ptr] <= '0;
                plru_q[ptr]  <= '0;
            end else if (up_we) begin
                for (int w = 0; w < WAYS; w++)
                    if (w == int'(up_way))
                        valid_q[up_idx][w] <= 1'b1;
                plru_q[up_idx] <= PLRU_W'(plru_nxt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (up_we) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w == int'(up_way)) begin
                    tag_q[up_idx][w] <= up_tag;
                    tgt_q[up_idx][w] <= upd_target;
                    cnt_q[up_idx][w] <= up_cnt;
                end
            end
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed testbench for btb_assoc (WIDTH=32, IDX_WIDTH=6, WAYS=2).
// Each scenario task drives stimulus and checks hand-computed results.
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_pc = '0;
    logic        rd_hit, rd_taken;
    logic [31:0] rd_target;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        flush = 1'b0;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    btb_assoc #(.WIDTH(32), .IDX_WIDTH(6), .WAYS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_pc(rd_pc),
        .rd_hit(rd_hit), .rd_taken(rd_taken), .rd_target(rd_target),
        .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken),
        .flush(flush), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk);
        upd_en = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic do_rd(input logic [31:0] pc);
        rd_en = 1'b1; rd_pc = pc;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        bit early_hit;
        rd_en = 1'b1; rd_pc = 32'h100;
        tick(); tick();
        n_vec++;
        if ({busy, rd_hit, rd_taken, rd_target} !== {3'b100, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got %h exp %h",
                     {busy, rd_hit, rd_taken, rd_target}, {3'b100, 32'h0});
        end
        rst_n = 1'b1;
        cnt = 0; early_hit = 1'b0;
        while (busy && cnt < 200) begin
            tick(); cnt++;
            if (rd_hit) early_hit = 1'b1;
        end
        n_vec++;
        if (cnt !== 64) begin
            n_bad++; $display("FAIL reset_busy_len: got %0d exp 64", cnt);
        end
        n_vec++;
        if (early_hit !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy_lookup: got hit 1 exp 0");
        end
        tick();
        rd_en = 1'b0;
        n_vec++;
        if (rd_hit !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_lookup: got %b exp 0", rd_hit);
        end
    endtask

    task automatic test_hit();
        do_upd(32'h40, 32'h1000, 1'b1);
        do_rd(32'h40);
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b11, 32'h1000}) begin
            n_bad++; $display("FAIL hit_basic: got %h exp %h",
                              {rd_hit, rd_taken, rd_target}, {2'b11, 32'h1000});
        end
        do_rd(32'h43);
        n_vec++;
        if ({rd_hit, rd_target} !== {1'b1, 32'h1000}) begin
            n_bad++; $display("FAIL hit_pc_lsbs: got %h exp %h",
                              {rd_hit, rd_target}, {1'b1, 32'h1000});
        end
        rd_pc = 32'h80;
        tick();
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b11, 32'h1000}) begin
            n_bad++; $display("FAIL hit_hold: got %h exp %h",
                              {rd_hit, rd_taken, rd_target}, {2'b11, 32'h1000});
        end
    endtask

    task automatic test_counter();
        do_upd(32'h40, 32'h1000, 1'b0);
        do_rd(32'h40);
        n_vec++;
        if ({rd_hit, rd_taken} !== 2'b10) begin
            n_bad++; $display("FAIL ctr_dec1: got %b exp 10", {rd_hit, rd_taken});
        end
        do_upd(32'h40, 32'h1000, 1'b0);
        do_upd(32'h40, 32'h1000, 1'b0);
        do_rd(32'h40);
        n_vec++;
        if ({rd_hit, rd_taken} !== 2'b10) begin
            n_bad++; $display("FAIL ctr_sat_low: got %b exp 10", {rd_hit, rd_taken});
        end
        for (int i = 0; i < 4; i++) do_upd(32'h40, 32'h1100, 1'b1);
        do_rd(32'h40);
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b11, 32'h1100}) begin
            n_bad++; $display("FAIL ctr_inc_target: got %h exp %h",
                              {rd_hit, rd_taken, rd_target}, {2'b11, 32'h1100});
        end
        do_upd(32'h40, 32'h1100, 1'b0);
        do_rd(32'h40);
        n_vec++;
        if ({rd_hit, rd_taken} !== 2'b11) begin
            n_bad++; $display("FAIL ctr_3_to_2: got %b exp 11", {rd_hit, rd_taken});
        end
        do_upd(32'h40, 32'h1100, 1'b0);
        do_rd(32'h40);
        n_vec++;
        if ({rd_hit, rd_taken} !== 2'b10) begin
            n_bad++; $display("FAIL ctr_sat_high: got %b exp 10", {rd_hit, rd_taken});
        end
    endtask

    task automatic test_evict();
        do_upd(32'h140, 32'h2140, 1'b1);
        do_upd(32'h240, 32'h2240, 1'b1);
        do_rd(32'h40);
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b00, 32'h0}) begin
            n_bad++; $display("FAIL evict_lru: got %h exp 0",
                              {rd_hit, rd_taken, rd_target});
        end
        do_rd(32'h140);
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b11, 32'h2140}) begin
            n_bad++; $display("FAIL evict_keep140: got %h exp %h",
                              {rd_hit, rd_taken, rd_target}, {2'b11, 32'h2140});
        end
        do_rd(32'h240);
        n_vec++;
        if ({rd_hit, rd_target} !== {1'b1, 32'h2240}) begin
            n_bad++; $display("FAIL evict_keep240: got %h exp %h",
                              {rd_hit, rd_target}, {1'b1, 32'h2240});
        end
        for (int i = 0; i < 3; i++) do_rd(32'h140);
        do_upd(32'h340, 32'h2340, 1'b1);
        do_rd(32'h140);
        n_vec++;
        if (rd_hit !== 1'b0) begin
            n_bad++; $display("FAIL plru_lookup_untouched: got %b exp 0", rd_hit);
        end
        do_rd(32'h340);
        n_vec++;
        if ({rd_hit, rd_target} !== {1'b1, 32'h2340}) begin
            n_bad++; $display("FAIL evict_alloc340: got %h exp %h",
                              {rd_hit, rd_target}, {1'b1, 32'h2340});
        end
        do_upd(32'h240, 32'h2240, 1'b1);
        do_upd(32'h440, 32'h2440, 1'b1);
        do_rd(32'h340);
        n_vec++;
        if (rd_hit !== 1'b0) begin
            n_bad++; $display("FAIL plru_hit_mru: got %b exp 0", rd_hit);
        end
        do_rd(32'h240);
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b11, 32'h2240}) begin
            n_bad++; $display("FAIL plru_hit_kept: got %h exp %h",
                              {rd_hit, rd_taken, rd_target}, {2'b11, 32'h2240});
        end
    endtask

    task automatic test_not_taken_miss();
        do_upd(32'h80, 32'h9999, 1'b0);
        do_rd(32'h80);
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b00, 32'h0}) begin
            n_bad++; $display("FAIL nt_miss_alloc: got %h exp 0",
                              {rd_hit, rd_taken, rd_target});
        end
        do_upd(32'h540, 32'h9999, 1'b0);
        do_rd(32'h440);
        n_vec++;
        if ({rd_hit, rd_target} !== {1'b1, 32'h2440}) begin
            n_bad++; $display("FAIL nt_miss_full_set: got %h exp %h",
                              {rd_hit, rd_target}, {1'b1, 32'h2440});
        end
    endtask

    task automatic test_back_to_back();
        rd_en = 1'b1; rd_pc = 32'h1004;
        upd_en = 1'b1; upd_pc = 32'h1004; upd_target = 32'h2000; upd_taken = 1'b1;
        tick();
        upd_en = 1'b0; rd_en = 1'b0;
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b00, 32'h0}) begin
            n_bad++; $display("FAIL rbw_alloc: got %h exp 0",
                              {rd_hit, rd_taken, rd_target});
        end
        rd_en = 1'b1;
        upd_en = 1'b1; upd_target = 32'h3000;
        tick();
        upd_en = 1'b0;
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b11, 32'h2000}) begin
            n_bad++; $display("FAIL rbw_hit: got %h exp %h",
                              {rd_hit, rd_taken, rd_target}, {2'b11, 32'h2000});
        end
        tick();
        n_vec++;
        if ({rd_hit, rd_target} !== {1'b1, 32'h3000}) begin
            n_bad++; $display("FAIL b2b_0: got %h exp %h",
                              {rd_hit, rd_target}, {1'b1, 32'h3000});
        end
        rd_pc = 32'h240;
        tick();
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b11, 32'h2240}) begin
            n_bad++; $display("FAIL b2b_1: got %h exp %h",
                              {rd_hit, rd_taken, rd_target}, {2'b11, 32'h2240});
        end
        rd_pc = 32'h340;
        tick();
        rd_en = 1'b0;
        n_vec++;
        if ({rd_hit, rd_taken, rd_target} !== {2'b00, 32'h0}) begin
            n_bad++; $display("FAIL b2b_2: got %h exp 0",
                              {rd_hit, rd_taken, rd_target});
        end
    endtask

    task automatic test_busy_ignore();
        int cnt;
        do_upd(32'hFC, 32'h0F00, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL flush_busy: got %b exp 1", busy);
        end
        cnt = 0;
        while (busy && cnt < 200) begin
            if (cnt == 20) begin
                upd_en = 1'b1; upd_pc = 32'h40;
                upd_target = 32'h7000; upd_taken = 1'b1;
                rd_en = 1'b1; rd_pc = 32'hFC; flush = 1'b1;
            end
            tick(); cnt++;
            if (cnt == 21) begin
                upd_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
                n_vec++;
                if ({rd_hit, rd_target} !== {1'b0, 32'h0}) begin
                    n_bad++; $display("FAIL busy_lookup: got %h exp 0",
                                      {rd_hit, rd_target});
                end
            end
        end
        n_vec++;
        if (cnt !== 64) begin
            n_bad++; $display("FAIL flush_no_restart: got %0d exp 64", cnt);
        end
        do_rd(32'h40);
        n_vec++;
        if (rd_hit !== 1'b0) begin
            n_bad++; $display("FAIL busy_upd_dropped: got %b exp 0", rd_hit);
        end
        do_rd(32'hFC);
        n_vec++;
        if (rd_hit !== 1'b0) begin
            n_bad++; $display("FAIL flush_cleared: got %b exp 0", rd_hit);
        end
    endtask

    task automatic test_flush_reset();
        int cnt;
        bit any_hit;
        logic [31:0] pcs [4];
        pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'hFC; pcs[3] = 32'h140;
        do_upd(32'h40, 32'h1000, 1'b1);
        do_upd(32'hFC, 32'h10FC, 1'b1);
        do_upd(32'h80, 32'h1080, 1'b1);
        do_rd(32'h80);
        n_vec++;
        if ({rd_hit, rd_target} !== {1'b1, 32'h1080}) begin
            n_bad++; $display("FAIL refill: got %h exp %h",
                              {rd_hit, rd_target}, {1'b1, 32'h1080});
        end
        flush = 1'b1;
        upd_en = 1'b1; upd_pc = 32'h140; upd_target = 32'h5000; upd_taken = 1'b1;
        tick();
        flush = 1'b0; upd_en = 1'b0;
        cnt = 0;
        while (cnt < 30) begin tick(); cnt++; end
        rst_n = 1'b0;
        tick();
        n_vec++;
        if ({busy, rd_hit, rd_target} !== {2'b10, 32'h0}) begin
            n_bad++; $display("FAIL midclear_reset: got %h exp %h",
                              {busy, rd_hit, rd_target}, {2'b10, 32'h0});
        end
        rst_n = 1'b1;
        cnt = 0;
        while (busy && cnt < 200) begin tick(); cnt++; end
        n_vec++;
        if (cnt !== 64) begin
            n_bad++; $display("FAIL restart_len: got %0d exp 64", cnt);
        end
        any_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_rd(pcs[i]);
            if (rd_hit) any_hit = 1'b1;
        end
        n_vec++;
        if (any_hit !== 1'b0) begin
            n_bad++; $display("FAIL post_flush_miss: got hit 1 exp 0");
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_counter();
        test_evict();
        test_not_taken_miss();
        test_back_to_back();
        test_busy_ignore();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
